// File: rtl/eth_tx_packet_arbiter.sv
// Four-source round-robin packet arbiter feeding one 16-bit AXI-Stream toward the UDP flow buffer.
// Define ARB_TIMEOUT_EN to add stall-timeout termination (TERM/DRAIN states).
module eth_tx_packet_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        link_up,
    input  logic [63:0] s_axis_tdata,
    input  logic [3:0]  s_axis_tvalid,
    input  logic [3:0]  s_axis_tlast,
    input  logic [3:0]  s_axis_tuser,
    output logic [3:0]  s_axis_tready,
    output logic [15:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    input  logic        m_axis_tready,
    output logic [3:0]  grant,
    output logic        busy
);

    localparam int unsigned NPORT = 4;
    localparam int unsigned DW    = 16;

    // The stall counter is 16 bits wide, so the limit must fit in it.
    if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES out of range 1..65535");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1
`ifdef ARB_TIMEOUT_EN
        ,
        TERM  = 2'd2,
        DRAIN = 2'd3
`endif
    } state_t;

    state_t            state_q;
    logic [1:0]        gidx_q;
    logic [1:0]        rr_ptr_q;
    logic [NPORT-1:0]  grant_q;
`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CW = 16;
    logic [CW-1:0]     cnt_q;
`endif

    logic [1:0]        pick_idx;
    logic [1:0]        idx;
    logic              found;
    logic              g_valid;
    logic              g_last;
    logic              g_user;
    logic [DW-1:0]     g_data;
    logic              g_hs;

    // Round-robin search starting at rr_ptr, wrapping modulo 4.
    always_comb begin
        pick_idx = rr_ptr_q;
        idx      = rr_ptr_q;
        found    = 1'b0;
        for (int k = 0; k < NPORT; k++) begin
            idx = rr_ptr_q + 2'(k);
            if (!found && s_axis_tvalid[idx]) begin
                pick_idx = idx;
                found    = 1'b1;
            end
        end
    end

    assign g_valid = s_axis_tvalid[gidx_q];
    assign g_last  = s_axis_tlast[gidx_q];
    assign g_user  = s_axis_tuser[gidx_q];
    assign g_data  = s_axis_tdata[{gidx_q, 4'b0000} +: DW];
    assign g_hs    = g_valid & m_axis_tready;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q  <= IDLE;
            gidx_q   <= 2'd0;
            rr_ptr_q <= 2'd0;
            grant_q  <= '0;
`ifdef ARB_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (link_up && found) begin
                        state_q <= GRANT;
                        gidx_q  <= pick_idx;
                        grant_q <= 4'b0001 << pick_idx;
`ifdef ARB_TIMEOUT_EN
                        cnt_q   <= '0;
`endif
                    end
                end
                GRANT: begin
                    if (g_hs && g_last) begin
                        state_q  <= IDLE;
                        rr_ptr_q <= gidx_q + 2'd1;
                        grant_q  <= '0;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (g_hs) begin
                        cnt_q <= '0;
                    end else if (!g_valid) begin
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q + CW'(1) == CW'(TIMEOUT_CYCLES))
                            state_q <= TERM;
                    end
`endif
                end
`ifdef ARB_TIMEOUT_EN
                TERM: begin
                    if (m_axis_tready)
                        state_q <= DRAIN;
                end
                DRAIN: begin
                    if (g_valid && g_last) begin
                        state_q  <= IDLE;
                        rr_ptr_q <= gidx_q + 2'd1;
                        grant_q  <= '0;
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    // Stream muxing; everything is held quiet while reset is asserted.
    always_comb begin
        s_axis_tready = '0;
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        if (aresetn) begin
            case (state_q)
                IDLE: begin
                    if (!link_up)
                        s_axis_tready = '1;
                end
                GRANT: begin
                    m_axis_tdata  = g_data;
                    m_axis_tvalid = g_valid;
                    m_axis_tlast  = g_last;
                    m_axis_tuser  = g_user;
                    s_axis_tready = grant_q & {NPORT{m_axis_tready}};
                end
`ifdef ARB_TIMEOUT_EN
                TERM: begin
                    m_axis_tvalid = 1'b1;
                    m_axis_tlast  = 1'b1;
                    m_axis_tuser  = 1'b1;
                end
                DRAIN: begin
                    s_axis_tready = grant_q;
                end
`endif
                default: ;
            endcase
        end
    end

    assign grant = grant_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_eth_tx_packet_arbiter.sv
// Scoreboard bench for eth_tx_packet_arbiter: per-port source queues, expected-beat queue checked at the output.
module tb_eth_tx_packet_arbiter;

    typedef struct packed {
        logic [15:0] d;
        logic        l;
        logic        u;
    } beat_t;

    typedef struct packed {
        beat_t      b;
        logic [3:0] g;
    } exp_t;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        link_up;
    logic [63:0] s_axis_tdata;
    logic [3:0]  s_axis_tvalid;
    logic [3:0]  s_axis_tlast;
    logic [3:0]  s_axis_tuser;
    logic [3:0]  s_axis_tready;
    logic [15:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic        m_axis_tready;
    logic [3:0]  grant;
    logic        busy;

    beat_t src_q[4][$];
    exp_t  exp_q[$];
    logic [3:0] hs_n = '0;
    logic  tog_mode = 1'b0;
    logic  rdy_ph = 1'b0;
    logic  gap_pend = 1'b0;
    int    out_cnt = 0;
    int    n_chk = 0;
    int    n_pass = 0;

    eth_tx_packet_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .aclk(aclk), .aresetn(aresetn), .link_up(link_up),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .m_axis_tready(m_axis_tready), .grant(grant), .busy(busy)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    task automatic load_pkt(input int p, input int n, input logic [15:0] base,
                            input logic fwd, input logic user_first);
        beat_t bt;
        exp_t  e;
        for (int b = 0; b < n; b++) begin
            bt.d = base + 16'(b);
            bt.l = (b == n - 1);
            bt.u = user_first && (b == 0);
            src_q[p].push_back(bt);
            if (fwd) begin
                e.b = bt;
                e.g = 4'b0001 << p;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #2;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            tick();
            c++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
        repeat (3) tick();
    endtask

    task automatic do_reset();
        tick();
        aresetn  = 1'b0;
        link_up  = 1'b0;
        tog_mode = 1'b0;
        for (int i = 0; i < 4; i++) src_q[i].delete();
        exp_q.delete();
        repeat (2) tick();
        @(negedge aclk);
        check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_tready", 32'(s_axis_tready), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        tick();
        aresetn = 1'b1;
    endtask

    // Drives all source-side inputs and m_axis_tready once per cycle.
    initial begin
        s_axis_tdata  = '0;
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        s_axis_tuser  = '0;
        m_axis_tready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            for (int i = 0; i < 4; i++)
                if (hs_n[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            rdy_ph = ~rdy_ph;
            m_axis_tready = tog_mode ? rdy_ph : 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (src_q[i].size() > 0) begin
                    s_axis_tvalid[i]         = 1'b1;
                    s_axis_tdata[16*i +: 16] = src_q[i][0].d;
                    s_axis_tlast[i]          = src_q[i][0].l;
                    s_axis_tuser[i]          = src_q[i][0].u;
                end else begin
                    s_axis_tvalid[i]         = 1'b0;
                    s_axis_tdata[16*i +: 16] = 16'h0;
                    s_axis_tlast[i]          = 1'b0;
                    s_axis_tuser[i]          = 1'b0;
                end
            end
        end
    end

    initial forever begin
        @(negedge aclk);
        hs_n = s_axis_tvalid & s_axis_tready;
    end

    // Output monitor: pops the scoreboard on every m-side handshake.
    initial forever begin
        exp_t e;
        @(negedge aclk);
        if (gap_pend) begin
            check("idle_gap", 32'(m_axis_tvalid), 32'd0);
            gap_pend = 1'b0;
        end
        if (aresetn && m_axis_tvalid && m_axis_tready) begin
            out_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_beat", {16'h0, m_axis_tdata}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("tdata", 32'(m_axis_tdata), 32'(e.b.d));
                check("tlast", 32'(m_axis_tlast), 32'(e.b.l));
                check("tuser", 32'(m_axis_tuser), 32'(e.b.u));
                check("grant", 32'(grant), 32'(e.g));
            end
            if (m_axis_tlast) gap_pend = 1'b1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int base;
        aresetn = 1'b0;
        link_up = 1'b0;

        // Two competing 3-beat packets: port 0 first, then port 2.
        do_reset();
        link_up = 1'b1;
        load_pkt(0, 3, 16'h0100, 1'b1, 1'b1);
        load_pkt(2, 3, 16'h2100, 1'b1, 1'b0);
        wait_drain("pair_done", 200);
        check("pair_idle_busy", 32'(busy), 32'd0);

        // All four ports continuously requesting: strict rotation 0,1,2,3,0,1,2,3.
        do_reset();
        link_up = 1'b1;
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < 4; p++)
                load_pkt(p, 2, 16'(p * 16'h1000 + r * 16'h0100), 1'b0, 1'b0);
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < 4; p++) begin
                exp_t e;
                for (int b = 0; b < 2; b++) begin
                    e.b.d = 16'(p * 16'h1000 + r * 16'h0100 + b);
                    e.b.l = (b == 1);
                    e.b.u = 1'b0;
                    e.g   = 4'b0001 << p;
                    exp_q.push_back(e);
                end
            end
        wait_drain("rr_done", 400);

        // Link down: port 1 beats are accepted and dropped, nothing emitted.
        do_reset();
        load_pkt(1, 5, 16'h1500, 1'b0, 1'b0);
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge aclk);
            if (s_axis_tvalid[1]) begin
                cnt++;
                check("discard_tready", 32'(s_axis_tready[1]), 32'd1);
                check("discard_tvalid", 32'(m_axis_tvalid), 32'd0);
            end
        end
        check("discard_cnt", 32'(cnt), 32'd5);

        // Link drops mid-packet: the packet still completes, then discard mode.
        do_reset();
        link_up = 1'b1;
        base = out_cnt;
        load_pkt(3, 4, 16'h3400, 1'b1, 1'b0);
        cnt = 0;
        while (out_cnt < base + 2 && cnt < 50) begin
            tick();
            cnt++;
        end
        check("linkdrop_reach2", 32'(out_cnt >= base + 2), 32'd1);
        link_up = 1'b0;
        wait_drain("linkdrop_done", 100);
        @(negedge aclk);
        check("linkdrop_busy", 32'(busy), 32'd0);
        check("linkdrop_tready", 32'(s_axis_tready), 32'hF);
        tick();
        load_pkt(1, 2, 16'h1200, 1'b0, 1'b0);
        repeat (10) tick();
        check("linkdrop_discard", 32'(src_q[1].size()), 32'd0);

        // Backpressure toggling on a 6-beat packet 0x0001..0x0006.
        do_reset();
        link_up  = 1'b1;
        tog_mode = 1'b1;
        load_pkt(2, 6, 16'h0001, 1'b1, 1'b0);
        wait_drain("bp_done", 200);
        tog_mode = 1'b0;

`ifdef ARB_TIMEOUT_EN
        // Stall after one beat: terminator beat, drain the rest, then port 1.
        do_reset();
        link_up = 1'b1;
        load_pkt(0, 1, 16'hA000, 1'b1, 1'b0);
        exp_q[0].b.l = 1'b0;
        src_q[0][0].l = 1'b0;
        begin
            exp_t e;
            e.b.d = 16'h0000;
            e.b.l = 1'b1;
            e.b.u = 1'b1;
            e.g   = 4'b0001;
            exp_q.push_back(e);
        end
        wait_drain("to_term", 100);
        load_pkt(0, 3, 16'hA100, 1'b0, 1'b0);
        load_pkt(1, 2, 16'h1A00, 1'b1, 1'b0);
        wait_drain("to_next", 100);
        check("to_drained", 32'(src_q[0].size()), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
